// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Build option: define IMEM_LOADER_CHECKSUM_EN to add the trailing XOR checksum check.
package imem_loader_pkg;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [31:0] HALT_WORD      = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , ST_CHECK
`endif
  } state_e;

endpackage

// File: rtl/imem_loader_assembler.sv
// Byte-to-word assembler: packs little-endian bytes into a 32-bit word.
// word_ready flags the cycle in which the last byte of a word is being loaded.
module imem_loader_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      word_q, word_d;
  logic [31:0]      word_next;

  // Next word/index: insert the incoming byte at the current byte lane.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    word_d     = word_q;
    idx_d      = idx_q;
    word_next  = word_q;
    word_next[{idx_q, 3'b000} +: 8] = byte_in;
    word_ready = load && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    if (clear) begin
      word_d = '0;
      idx_d  = '0;
    end else if (load) begin
      word_d = word_next;
      idx_d  = idx_q + IDX_W'(1);  // wraps to lane 0 after the last byte
    end
  end

  // Shift-register state; reset discards any partial word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a byte stream, writes 32-bit words
// until a zero terminator, then releases the CPU from reset.
// Build option: IMEM_LOADER_CHECKSUM_EN appends a 32-bit XOR checksum word
// after the terminator, checked before the CPU is released.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   word_count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       acc_q, acc_d;
`endif

  logic        asm_clear, asm_load, word_ready, restart;
  logic [31:0] word;

  imem_loader_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .load       (asm_load),
    .byte_in    (rx_data),
    .word       (word),
    .word_ready (word_ready)
  );

  // Next-state and Moore outputs of the load sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    acc_d      = acc_q;
`endif
    asm_clear  = 1'b0;
    asm_load   = 1'b0;
    restart    = 1'b0;
    rx_ready   = 1'b0;
    imem_we    = 1'b0;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;

    case (state_q)
      ST_IDLE: restart = start;
      ST_RECV: begin
        rx_ready = 1'b1;
        asm_load = rx_valid;
        if (word_ready) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        imem_we = 1'b1;
        count_d = count_q + (ADDR_W + 1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        acc_d   = acc_q ^ word;
`endif
        if (word == HALT_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else if (addr_q == {ADDR_W{1'b1}}) begin
          state_d = ST_ERROR;  // memory full, stream still running
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        rx_ready = 1'b1;
        asm_load = rx_valid;
        // Last checksum byte is still on rx_data; compare the full word now.
        if (word_ready) state_d = ({rx_data, word[23:0]} == acc_q) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
        restart   = start;
      end
      ST_ERROR: begin
        load_error = 1'b1;
        restart    = start;
      end
      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      state_d   = ST_RECV;
      addr_d    = '0;
      count_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_d     = '0;
`endif
      asm_clear = 1'b1;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = word;
  assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W=2 so overflow is reachable).
// A stream-level model predicts writes and status every cycle; literal
// expectations pin the key results of each scenario.
module tb_imem_loader;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   word_count;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  // ---------------- stream-level model ----------------
  typedef enum {P_IDLE, P_DATA, P_CHK, P_OK, P_ERR} phase_e;
  phase_e      m_phase;
  logic        m_we;       // a write is due this cycle
  logic [31:0] m_word;
  logic [31:0] m_acc;
  int          m_nb, m_addr, m_count;
  logic        exp_ready;
  logic [31:0] wr_mem [DEPTH];
  int          we_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_phase = P_IDLE; m_we = 1'b0; m_nb = 0; m_addr = 0; m_count = 0;
        m_word = '0; m_acc = '0;
      end else begin
        exp_ready = (m_phase == P_DATA || m_phase == P_CHK) && !m_we;
        check("rx_ready",   rx_ready,   exp_ready);
        check("imem_we",    imem_we,    m_we);
        check("cpu_hold",   cpu_hold,   m_phase != P_OK);
        check("load_done",  load_done,  m_phase == P_OK);
        check("load_error", load_error, m_phase == P_ERR);
        check("word_count", word_count, m_count);
        if (m_we && imem_we) begin
          check("imem_addr",  imem_addr,  m_addr);
          check("imem_wdata", imem_wdata, m_word);
        end
        if (imem_we) begin
          wr_mem[imem_addr] = imem_wdata;
          we_cnt++;
        end
        // advance the model by what happens at the coming edge
        if (m_we) begin
          m_we = 1'b0;
          m_count++;
          m_acc ^= m_word;
          if (m_word == 32'h0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            m_phase = P_CHK;
`else
            m_phase = P_OK;
`endif
          end else if (m_addr == DEPTH - 1) m_phase = P_ERR;
          else m_addr++;
        end else if (exp_ready && rx_valid) begin
          m_word[8*m_nb +: 8] = rx_data;
          m_nb++;
          if (m_nb == 4) begin
            m_nb = 0;
            if (m_phase == P_DATA) m_we = 1'b1;
            else m_phase = (m_word == m_acc) ? P_OK : P_ERR;
          end
        end else if (start && (m_phase == P_IDLE || m_phase == P_OK || m_phase == P_ERR)) begin
          m_phase = P_DATA; m_nb = 0; m_addr = 0; m_count = 0; m_acc = '0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] tx_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 40) begin
      tick();
      n++;
    end
    check("handshake", rx_ready, 1'b1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_q(input bit throttle);
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], throttle ? (i % 3) + 1 : 0);
  endtask

  task automatic load_stream1();
    tx_q = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    tx_q.push_back(8'h80); tx_q.push_back(8'h00); tx_q.push_back(8'hB0); tx_q.push_back(8'h00);
`endif
  endtask

  int base;

  initial begin
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) tick();
    check("rst_rx_ready",   rx_ready,   1'b0);
    check("rst_imem_we",    imem_we,    1'b0);
    check("rst_imem_addr",  imem_addr,  0);
    check("rst_imem_wdata", imem_wdata, 32'h0);
    check("rst_cpu_hold",   cpu_hold,   1'b1);
    check("rst_load_done",  load_done,  1'b0);
    check("rst_load_error", load_error, 1'b0);
    check("rst_word_count", word_count, 0);
    reset = 1'b1;
    tick();

    // Load without gaps.
    base = we_cnt;
    pulse_start();
    load_stream1();
    send_q(1'b0);
    repeat (3) tick();
    check("l1_mem0",       wr_mem[0], 32'h00A0_0513);
    check("l1_mem1",       wr_mem[1], 32'h0010_0593);
    check("l1_mem2",       wr_mem[2], 32'h0000_0000);
    check("l1_writes",     we_cnt - base, 3);
    check("l1_word_count", word_count, 3);
    check("l1_load_done",  load_done, 1'b1);
    check("l1_cpu_hold",   cpu_hold, 1'b0);

    // Reload from DONE with a throttled source.
    wr_mem[0] = 32'hDEAD_BEEF;
    base = we_cnt;
    pulse_start();
    check("rl_cpu_hold",   cpu_hold, 1'b1);
    check("rl_imem_addr",  imem_addr, 0);
    check("rl_word_count", word_count, 0);
    check("rl_load_done",  load_done, 1'b0);
    send_q(1'b1);
    repeat (3) tick();
    check("l2_mem0",      wr_mem[0], 32'h00A0_0513);
    check("l2_mem1",      wr_mem[1], 32'h0010_0593);
    check("l2_writes",    we_cnt - base, 3);
    check("l2_load_done", load_done, 1'b1);

    // Overflow: four nonzero words fill the 4-word memory.
    base = we_cnt;
    pulse_start();
    tx_q = {};
    for (int j = 0; j < 4; j++) begin
      tx_q.push_back(8'(j + 1)); tx_q.push_back(8'h10); tx_q.push_back(8'h20); tx_q.push_back(8'h30);
    end
    send_q(1'b0);
    repeat (6) tick();
    check("ov_mem0",       wr_mem[0], 32'h3020_1001);
    check("ov_mem3",       wr_mem[3], 32'h3020_1004);
    check("ov_writes",     we_cnt - base, 4);
    check("ov_load_error", load_error, 1'b1);
    check("ov_cpu_hold",   cpu_hold, 1'b1);
    check("ov_rx_ready",   rx_ready, 1'b0);
    check("ov_word_count", word_count, 4);

    // Reset after two bytes of word 0.
    pulse_start();
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    reset = 1'b0;
    #1;
    check("mr_rx_ready",   rx_ready,   1'b0);
    check("mr_imem_we",    imem_we,    1'b0);
    check("mr_imem_addr",  imem_addr,  0);
    check("mr_imem_wdata", imem_wdata, 32'h0);
    check("mr_cpu_hold",   cpu_hold,   1'b1);
    check("mr_load_error", load_error, 1'b0);
    check("mr_word_count", word_count, 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    pulse_start();
    tx_q = '{8'h13, 8'h05, 8'hA0, 8'h00};
    send_q(1'b0);
    repeat (2) tick();
    check("mr_mem0", wr_mem[0], 32'h00A0_0513);
    tx_q = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    tx_q.push_back(8'h13); tx_q.push_back(8'h05); tx_q.push_back(8'hA0); tx_q.push_back(8'h00);
`endif
    send_q(1'b0);
    repeat (3) tick();
    check("mr_load_done",  load_done, 1'b1);
    check("mr_word_count", word_count, 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum aborts the load.
    pulse_start();
    tx_q = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    send_q(1'b0);
    repeat (3) tick();
    check("ck_load_error", load_error, 1'b1);
    check("ck_load_done",  load_done, 1'b0);
    check("ck_cpu_hold",   cpu_hold, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
